// File: rtl/xgen_pkg.sv
// Shared constants for xgen_seq: word format, entry indices, FSM encoding and
// the per-link coefficient tables (entry = CC*cos + CS*sin + K, Q16.16).
package xgen_pkg;

    localparam int XG_WIDTH        = 32;
    localparam int XG_DECIMAL_BITS = 16;
    localparam int XG_NUM_LINKS    = 7;
    localparam int XG_LINK_BITS    = 3;
    localparam int XG_ENTRIES      = 18;

    localparam int E_AX_AX = 0,  E_AX_AY = 1,  E_AX_AZ = 2;
    localparam int E_AY_AX = 3,  E_AY_AY = 4,  E_AY_AZ = 5;
    localparam int E_AZ_AX = 6,  E_AZ_AY = 7,  E_AZ_AZ = 8;
    localparam int E_LX_AX = 9,  E_LX_AY = 10, E_LX_AZ = 11;
    localparam int E_LY_AX = 12, E_LY_AY = 13, E_LY_AZ = 14;
    localparam int E_LZ_AX = 15, E_LZ_AY = 16, E_LZ_AZ = 17;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int P1 = 65536;
    localparam int M1 = -65536;

    typedef logic signed [XG_WIDTH-1:0] coef_t;

    // Rows are links 0..6; columns follow the E_* entry order above.
    localparam coef_t CC [XG_NUM_LINKS][XG_ENTRIES] = '{
        '{P1,0,0, 0,P1,0, 0,0,0, 0,0,0,     0,0,0,      0,0,0},
        '{P1,0,0, 0,0,P1, 0,0,0, 0,14123,0, 0,0,0,      0,0,0},
        '{P1,0,0, 0,0,P1, 0,0,0, 0,26571,0, 0,0,0,      0,0,0},
        '{P1,0,0, 0,0,M1, 0,0,0, 0,0,0,     0,0,20316,  0,0,0},
        '{P1,0,0, 0,P1,0, 0,0,0, 0,0,0,     0,0,0,      8204,0,0},
        '{P1,0,0, 0,0,P1, 0,0,0, 0,0,0,     0,0,0,      0,0,0},
        '{P1,0,0, 0,0,M1, 0,0,0, 0,-3300,0, 0,0,0,      0,0,0}
    };

    localparam coef_t CS [XG_NUM_LINKS][XG_ENTRIES] = '{
        '{0,P1,0, M1,0,0, 0,0,0, 0,0,0, 0,0,0,      0,0,0},
        '{0,0,P1, M1,0,0, 0,0,0, 0,0,0, 0,-14123,0, 0,0,0},
        '{0,0,M1, P1,0,0, 0,0,0, 0,0,0, 0,-26571,0, 0,0,0},
        '{0,0,P1, P1,0,0, 0,0,0, 0,0,0, 0,0,0,      0,-20316,0},
        '{0,P1,0, M1,0,0, 0,0,0, 0,0,0, 0,0,0,      0,8204,0},
        '{0,0,P1, M1,0,0, 0,0,0, 0,0,0, 0,0,0,      0,0,0},
        '{0,0,P1, P1,0,0, 0,0,0, 0,0,0, 0,3300,0,   0,0,0}
    };

    localparam coef_t K [XG_NUM_LINKS][XG_ENTRIES] = '{
        '{0,0,0, 0,0,0, 0,0,P1, 0,0,0,     0,0,0, 0,0,0},
        '{0,0,0, 0,0,0, 0,M1,0, 0,0,0,     0,0,0, 14123,0,0},
        '{0,0,0, 0,0,0, 0,P1,0, 0,0,0,     0,0,0, -26571,0,0},
        '{0,0,0, 0,0,0, 0,P1,0, 0,0,0,     0,0,0, 0,0,0},
        '{0,0,0, 0,0,0, 0,0,P1, 0,0,-5120, 0,0,0, 0,0,0},
        '{0,0,0, 0,0,0, 0,M1,0, 0,0,0,     0,0,0, 0,0,0},
        '{0,0,0, 0,0,0, 0,P1,0, 0,0,0,     0,0,0, 11800,0,0}
    };

endpackage

// File: rtl/xgen_seq_if.sv
// Request/result handshake bundle between the trig unit, xgen_seq and the
// forward-pass datapath.
interface xgen_seq_if
    import xgen_pkg::*;
#(
    parameter int WIDTH     = XG_WIDTH,
    parameter int LINK_BITS = XG_LINK_BITS
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LINK_BITS-1:0]          link_in;
    logic signed [WIDTH-1:0]       sinq_in;
    logic signed [WIDTH-1:0]       cosq_in;
    logic                          out_valid;
    logic                          out_ready;
    logic [LINK_BITS-1:0]          out_link;
    logic                          out_err;
    logic [XG_ENTRIES*WIDTH-1:0]   xform_out;

    modport master (
        output in_valid, link_in, sinq_in, cosq_in, out_ready,
        input  in_ready, out_valid, out_link, out_err, xform_out
    );

    modport slave (
        input  in_valid, link_in, sinq_in, cosq_in, out_ready,
        output in_ready, out_valid, out_link, out_err, xform_out
    );
endinterface

// File: rtl/xgen_fxp_mul.sv
// Signed fixed-point multiply: full-width product, floor shift by DECIMAL_BITS,
// truncated back to WIDTH.
module fxp_mul
    import xgen_pkg::*;
#(
    parameter int WIDTH        = XG_WIDTH,
    parameter int DECIMAL_BITS = XG_DECIMAL_BITS
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_p
);
    logic signed [2*WIDTH-1:0] w_full;
    logic                      w_unused;

    assign w_full   = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    // Taking the slice is the arithmetic shift plus truncation in one step.
    assign o_p      = w_full[DECIMAL_BITS +: WIDTH];
    assign w_unused = ^{w_full[2*WIDTH-1:DECIMAL_BITS+WIDTH], w_full[DECIMAL_BITS-1:0]};
endmodule

// File: rtl/xgen_seq.sv
// Time-multiplexed 6x6 spatial transform generator: one table entry per cycle.
//   state  | meaning
//   S_IDLE | in_ready high, waiting for a request
//   S_CALC | writing entry r_cnt, 18 cycles
//   S_DONE | out_valid high, outputs held until out_ready
module xgen_seq
    import xgen_pkg::*;
#(
    parameter int WIDTH        = XG_WIDTH,
    parameter int DECIMAL_BITS = XG_DECIMAL_BITS,
    parameter int NUM_LINKS    = XG_NUM_LINKS,
    parameter int LINK_BITS    = XG_LINK_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    xgen_seq_if.slave  bus
);
    logic [1:0]                  r_state;
    logic [4:0]                  r_cnt;
    logic [LINK_BITS-1:0]        r_link;
    logic signed [WIDTH-1:0]     r_sin;
    logic signed [WIDTH-1:0]     r_cos;
    logic                        r_err;
    logic [XG_ENTRIES*WIDTH-1:0] r_xform;

    logic [LINK_BITS-1:0]        w_lidx;
    logic signed [WIDTH-1:0]     w_cc;
    logic signed [WIDTH-1:0]     w_cs;
    logic signed [WIDTH-1:0]     w_k;
    logic signed [WIDTH-1:0]     w_pc;
    logic signed [WIDTH-1:0]     w_ps;
    logic signed [WIDTH-1:0]     w_sum;

    // An out-of-range link never reaches the table; zero coefficients give zero entries.
    assign w_lidx = r_err ? '0 : r_link;
    assign w_cc   = r_err ? '0 : WIDTH'(CC[w_lidx][r_cnt]);
    assign w_cs   = r_err ? '0 : WIDTH'(CS[w_lidx][r_cnt]);
    assign w_k    = r_err ? '0 : WIDTH'(K[w_lidx][r_cnt]);

    fxp_mul #(.WIDTH(WIDTH), .DECIMAL_BITS(DECIMAL_BITS)) u_mul_cos (
        .i_a (w_cc),
        .i_b (r_cos),
        .o_p (w_pc)
    );

    fxp_mul #(.WIDTH(WIDTH), .DECIMAL_BITS(DECIMAL_BITS)) u_mul_sin (
        .i_a (w_cs),
        .i_b (r_sin),
        .o_p (w_ps)
    );

    assign w_sum = w_pc + w_ps + w_k;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_link  <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_err   <= 1'b0;
            r_xform <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_link  <= bus.link_in;
                        r_sin   <= bus.sinq_in;
                        r_cos   <= bus.cosq_in;
                        r_err   <= (int'(bus.link_in) >= NUM_LINKS);
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_xform[r_cnt*WIDTH +: WIDTH] <= w_sum;
                    if (r_cnt == 5'(E_LZ_AZ)) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.out_link  = r_link;
    assign bus.out_err   = r_err;
    assign bus.xform_out = r_xform;
endmodule
